// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one block-read instruction memory between the
// i-caches of two hardware contexts, with a sticky watchdog for hung fetches.
module imem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  c0_read,
    input  logic [ADDR_WIDTH-1:0] c0_address,
    output logic [DATA_WIDTH-1:0] c0_readdata,
    output logic                  c0_busywait,

    input  logic                  c1_read,
    input  logic [ADDR_WIDTH-1:0] c1_address,
    output logic [DATA_WIDTH-1:0] c1_readdata,
    output logic                  c1_busywait,

    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait,

    output logic                  timeout_err
);

    localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 grant;       // requester owning the current fetch
    logic                 grant_next;
    logic                 prio;        // requester favoured on a tie
    logic [CNT_WIDTH-1:0] wait_cnt;

    logic                 do_grant;
    logic                 do_capture;
    logic                 do_abort;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        grant_next = grant;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_abort   = 1'b0;

        case (state)
            IDLE: begin
                if (c0_read || c1_read) begin
                    do_grant   = 1'b1;
                    grant_next = (c0_read && c1_read) ? prio : c1_read;
                    state_next = ISSUE;
                end
            end
            // Memory busywait is derived from mem_read, so give it a cycle to settle.
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (!mem_busywait) begin
                    do_capture = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    do_abort   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    // NOTE: the returned-block registers are reset too, so a requester never
    // observes stale data after a reset aborts a fetch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_read    <= 1'b0;
            mem_address <= '0;
            c0_readdata <= '0;
            c1_readdata <= '0;
            timeout_err <= 1'b0;
            prio        <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (do_grant) begin
                mem_read    <= 1'b1;
                mem_address <= grant_next ? c1_address : c0_address;
            end
            if (do_capture || do_abort) begin
                mem_read <= 1'b0;
            end

            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // Data is returned even if the requester has since dropped its read.
            if (do_capture) begin
                if (grant) begin
                    c1_readdata <= mem_readdata;
                end else begin
                    c0_readdata <= mem_readdata;
                end
            end

            if (do_abort) begin
                timeout_err <= 1'b1;
            end

            if (state == RESP) begin
                prio <= ~grant;
            end
        end
    end

    assign c0_busywait = c0_read & ~((state == RESP) & (grant == 1'b0));
    assign c1_busywait = c1_read & ~((state == RESP) & (grant == 1'b1));

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vectors, hand-written corner
// sequences, and a randomized run against a fetch-level timing model.
module tb_imem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int TO = 64;
    localparam logic [DW-1:0] FIXED_BLOCK = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          c0_read = 1'b0;
    logic          c1_read = 1'b0;
    logic [AW-1:0] c0_address = '0;
    logic [AW-1:0] c1_address = '0;
    logic [DW-1:0] c0_readdata;
    logic [DW-1:0] c1_readdata;
    logic          c0_busywait;
    logic          c1_busywait;
    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;
    logic          timeout_err;

    always #5 clock = ~clock;

    imem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .c0_read     (c0_read),
        .c0_address  (c0_address),
        .c0_readdata (c0_readdata),
        .c0_busywait (c0_busywait),
        .c1_read     (c1_read),
        .c1_address  (c1_address),
        .c1_readdata (c1_readdata),
        .c1_busywait (c1_busywait),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait),
        .timeout_err (timeout_err)
    );

    // Distinct block contents per address.
    function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
        return {a, 4'h5, ~a, 4'hA, a ^ 28'h5A5A5A5, 4'h3, 32'hC0DE0000 | 32'(a[15:0])};
    endfunction

    // Instruction memory stub: busy for cur_busy cycles of WAIT, unless stuck.
    int unsigned mem_cnt = 0;
    int unsigned cur_busy = 0;
    logic        stuck = 1'b0;
    logic        use_fixed = 1'b0;

    always @(posedge clock) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
    assign mem_busywait = mem_read && (stuck || mem_cnt <= cur_busy);
    assign mem_readdata = use_fixed ? FIXED_BLOCK : blk(mem_address);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for the given requester's busywait to fall; returns cycles waited.
    task automatic wait_low(input string name, input logic req, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clock);
            if ((req ? c1_busywait : c0_busywait) == 1'b0) break;
            if (cyc >= 300) begin
                bound_fail(name);
                break;
            end
            tick();
            cyc++;
        end
    endtask

    // Called in an IDLE cycle with inputs already applied; ends in the cycle after RESP.
    task automatic run_fetch(input string name, input logic req, input logic [AW-1:0] addr,
                             input int busy);
        int            cyc;
        logic [DW-1:0] exp_data;
        exp_data = use_fixed ? FIXED_BLOCK : blk(addr);
        cyc = 0;
        forever begin
            @(negedge clock);
            if (cyc == 1) begin
                check1({name, " issue mem_read"}, mem_read, 1'b1);
                check({name, " mem_address"}, DW'(mem_address), DW'(addr));
            end
            if ((req ? c1_busywait : c0_busywait) == 1'b0) break;
            if (cyc >= 300) begin
                bound_fail(name);
                break;
            end
            tick();
            cyc++;
        end
        check_int({name, " latency"}, cyc, busy + 3);
        check1({name, " resp mem_read"}, mem_read, 1'b0);
        check({name, " readdata"}, req ? c1_readdata : c0_readdata, exp_data);
        check1({name, " other busywait"}, req ? c0_busywait : c1_busywait,
               req ? c0_read : c1_read);
        tick();
    endtask

    typedef struct {
        logic          r0;
        logic          r1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        int            busy;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[9];

    // Fetch-level reference model state for the randomized phase.
    int            m_phase;
    int            m_len;
    logic          m_grant;
    logic          m_prio;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rd[2];
    logic          rq[2];
    logic [AW-1:0] ra[2];
    logic          was_resp[2];

    initial begin
        #1_000_000;
        $display("FAIL global watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   low_cnt;
        int   low_at;
        int   c1_hi;
        int   hi;
        logic done;
        logic is_resp;

        vecs[0] = '{1'b1, 1'b0, 28'h1, 28'h2, 2, 1'b0, 28'h1};
        vecs[1] = '{1'b0, 1'b1, 28'h1, 28'h2, 0, 1'b1, 28'h2};
        vecs[2] = '{1'b1, 1'b1, 28'h1, 28'h2, 3, 1'b0, 28'h1};
        vecs[3] = '{1'b1, 1'b1, 28'h1, 28'h2, 1, 1'b1, 28'h2};
        vecs[4] = '{1'b1, 1'b1, 28'h1, 28'h2, 5, 1'b0, 28'h1};
        vecs[5] = '{1'b1, 1'b1, 28'h1, 28'h2, 0, 1'b1, 28'h2};
        vecs[6] = '{1'b1, 1'b0, 28'h1, 28'h2, 4, 1'b0, 28'h1};
        vecs[7] = '{1'b1, 1'b0, 28'h1, 28'h2, 1, 1'b0, 28'h1};
        vecs[8] = '{1'b1, 1'b1, 28'h1, 28'h2, 2, 1'b1, 28'h2};

        // Reset state.
        #3;
        check1("reset mem_read", mem_read, 1'b0);
        check("reset mem_address", DW'(mem_address), '0);
        check("reset c0_readdata", c0_readdata, '0);
        check("reset c1_readdata", c1_readdata, '0);
        check1("reset timeout_err", timeout_err, 1'b0);
        check1("reset c0_busywait", c0_busywait, 1'b0);
        #9 reset = 1'b1;
        tick();

        // Vector table: grants, round-robin alternation, back-to-back single requester.
        for (int v = 0; v < 9; v++) begin
            c0_read    = vecs[v].r0;
            c1_read    = vecs[v].r1;
            c0_address = vecs[v].a0;
            c1_address = vecs[v].a1;
            cur_busy   = vecs[v].busy;
            run_fetch($sformatf("vec%0d", v), vecs[v].exp_req, vecs[v].exp_addr, vecs[v].busy);
        end
        c0_read = 1'b0;
        c1_read = 1'b0;

        // Single fetch, memory busy 16 cycles: busywait low only at cycle 19.
        c0_read    = 1'b1;
        c0_address = 28'h0000002;
        cur_busy   = 16;
        use_fixed  = 1'b1;
        low_cnt = 0;
        low_at  = -1;
        c1_hi   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (k == 1) check("single mem_address", DW'(mem_address), DW'(28'h0000002));
            if (!c0_busywait) begin
                low_cnt++;
                low_at = k;
            end
            if (c1_busywait) c1_hi++;
            tick();
        end
        c0_read = 1'b0;
        check_int("single busywait low cycles", low_cnt, 1);
        check_int("single busywait low at", low_at, 19);
        check_int("single c1_busywait high cycles", c1_hi, 0);
        check("single c0_readdata", c0_readdata, FIXED_BLOCK);
        use_fixed = 1'b0;

        // Address change during WAIT is ignored.
        c1_read    = 1'b1;
        c1_address = 28'h5;
        cur_busy   = 6;
        repeat (3) tick();
        c1_address = 28'h9;
        wait_low("addr change", 1'b1, cyc);
        check("addr change mem_address", DW'(mem_address), DW'(28'h5));
        check("addr change c1_readdata", c1_readdata, blk(28'h5));
        tick();
        c1_read = 1'b0;

        // Requester abort: c0 drops read mid-WAIT while c1 starts waiting.
        c0_read    = 1'b1;
        c0_address = 28'h3;
        cur_busy   = 5;
        repeat (3) tick();
        c0_read    = 1'b0;
        c1_read    = 1'b1;
        c1_address = 28'h4;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clock);
            if (mem_read && !mem_busywait) done = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        if (!done) bound_fail("abort mem_busywait fall");
        tick();
        @(negedge clock);
        check1("abort resp mem_read", mem_read, 1'b0);
        check1("abort resp c0_busywait", c0_busywait, 1'b0);
        check("abort c0_readdata", c0_readdata, blk(28'h3));
        check1("abort resp c1_busywait", c1_busywait, 1'b1);
        tick();
        @(negedge clock);
        check1("abort idle mem_read", mem_read, 1'b0);
        tick();
        @(negedge clock);
        check1("abort c1 issue mem_read", mem_read, 1'b1);
        check("abort c1 mem_address", DW'(mem_address), DW'(28'h4));
        tick();
        wait_low("abort c1 fetch", 1'b1, cyc);
        check("abort c1_readdata", c1_readdata, blk(28'h4));
        tick();
        c1_read = 1'b0;

        // Timeout: memory stuck busy.
        c0_read    = 1'b1;
        c0_address = 28'h7;
        stuck      = 1'b1;
        hi   = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clock);
            if (mem_read) begin
                hi++;
                if (hi == 65) check1("timeout flag before abort", timeout_err, 1'b0);
            end else if (hi > 0) begin
                done = 1'b1;
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        if (!done) bound_fail("timeout mem_read fall");
        check_int("timeout WAIT cycles", hi - 1, TO);
        check1("timeout_err set", timeout_err, 1'b1);
        check("timeout c0_readdata unchanged", c0_readdata, blk(28'h3));
        check1("timeout resp c0_busywait", c0_busywait, 1'b0);
        tick();
        stuck      = 1'b0;
        c0_address = 28'h8;
        cur_busy   = 2;
        run_fetch("post-timeout", 1'b0, 28'h8, 2);
        check1("timeout_err sticky", timeout_err, 1'b1);

        // Asynchronous reset mid-WAIT.
        c0_address = 28'h9;
        cur_busy   = 20;
        repeat (4) tick();
        @(negedge clock);
        check1("pre-reset mem_read", mem_read, 1'b1);
        #1 reset = 1'b0;
        #1;
        check1("async reset mem_read", mem_read, 1'b0);
        check("async reset mem_address", DW'(mem_address), '0);
        check("async reset c0_readdata", c0_readdata, '0);
        check1("async reset timeout_err", timeout_err, 1'b0);
        check1("async reset c0_busywait", c0_busywait, 1'b1);
        c0_read = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;

        // Randomized run against the fetch-level model.
        m_phase = -1;
        m_len   = 0;
        m_grant = 1'b0;
        m_prio  = 1'b0;
        m_addr  = '0;
        for (int n = 0; n < 2; n++) begin
            m_rd[n]     = '0;
            rq[n]       = 1'b0;
            ra[n]       = '0;
            was_resp[n] = 1'b0;
        end
        for (int k = 0; k < 2000; k++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                if (!rq[n]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rq[n] = 1'b1;
                        ra[n] = AW'($urandom_range(0, 255));
                    end
                end else if (was_resp[n]) begin
                    rq[n] = ($urandom_range(0, 1) == 1);
                    ra[n] = AW'($urandom_range(0, 255));
                end else if ($urandom_range(0, 19) == 0) begin
                    rq[n] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    ra[n] = AW'($urandom_range(0, 255));
                end
            end
            c0_read    = rq[0];
            c1_read    = rq[1];
            c0_address = ra[0];
            c1_address = ra[1];
            @(negedge clock);

            is_resp = (m_phase > 0) && (m_phase == m_len + 3);
            check1("rand c0_busywait", c0_busywait, rq[0] && !(is_resp && m_grant == 1'b0));
            check1("rand c1_busywait", c1_busywait, rq[1] && !(is_resp && m_grant == 1'b1));
            check1("rand mem_read", mem_read, (m_phase >= 1) && (m_phase <= m_len + 2));
            check("rand mem_address", DW'(mem_address), DW'(m_addr));
            check("rand c0_readdata", c0_readdata, m_rd[0]);
            check("rand c1_readdata", c1_readdata, m_rd[1]);
            check1("rand timeout_err", timeout_err, 1'b0);

            was_resp[0] = is_resp && (m_grant == 1'b0);
            was_resp[1] = is_resp && (m_grant == 1'b1);
            if (m_phase < 0) begin
                if (rq[0] || rq[1]) begin
                    m_grant  = (rq[0] && rq[1]) ? m_prio : rq[1];
                    m_addr   = ra[m_grant];
                    m_len    = $urandom_range(0, 6);
                    cur_busy = m_len;
                    m_phase  = 1;
                end
            end else if (is_resp) begin
                m_prio  = !m_grant;
                m_phase = -1;
            end else begin
                if (m_phase == m_len + 2) m_rd[m_grant] = blk(m_addr);
                m_phase++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
